// File: rtl/var_unit.sv
// var_unit: variance stage of the AILayerNorm datapath.
// Accumulates squares of the PTF-scaled sample stream, combines the sum with
// the mean from the Ex unit and returns Var = E[x^2] - E[x]^2 (clamped at 0)
// through a valid/ready handshake.
// Optional build macro: VAR_EPS_EN adds i_eps, which is added to the result
// with saturation.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for the first beat of a vector (the beat is accumulated)
// ACC     | accumulating squares until SAMPLES beats are in
// WAIT_EX | all beats in, waiting for the Ex unit's mean
// CALC    | register E[x^2] and E[x]^2
// SUB     | form the difference, clamp, raise o_var_valid
// HOLD    | result presented, waiting for i_var_ready
module var_unit #(
    parameter int SAMPLES = 8,
    parameter int XW      = 9
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    input  logic [XW-1:0] i_x,
    input  logic [1:0]    i_alpha,
    input  logic [7:0]    i_inv_n,
    input  logic          i_Ex_done,
    input  logic [21:0]   i_Ex,
    input  logic          i_var_ready,
`ifdef VAR_EPS_EN
    input  logic [7:0]    i_eps,
`endif
    output logic          o_var_valid,
    output logic [25:0]   o_var,
    output logic          o_clamp,
    output logic          o_busy
);

    localparam int CW = $clog2(SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WAIT_EX,
        S_CALC,
        S_SUB,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [25:0]           acc_q, acc_d;
    logic signed [12:0]    ex_q, ex_d;
    logic                  ex_seen_q, ex_seen_d;
    logic [25:0]           ex2_q, ex2_d;
    logic [24:0]           exsq_q, exsq_d;
    logic [25:0]           var_q, var_d;
    logic                  clamp_q, clamp_d;
    logic                  valid_q, valid_d;

    logic signed [11:0]    x_ext;
    logic signed [11:0]    sx;
    logic signed [22:0]    sx_w;
    logic [22:0]           sq;
    logic signed [12:0]    ex_sat;
    logic signed [24:0]    ex_w;
    logic signed [26:0]    diff;
    logic [25:0]           pos;
    logic                  ex_capture;

    // PTF scaling and square; the low 23 bits of the widened product are the
    // exact square because |sx| <= 2048.
    assign x_ext = {{(12-XW){i_x[XW-1]}}, i_x};
    assign sx    = x_ext <<< i_alpha;
    assign sx_w  = 23'(sx);
    assign sq    = sx_w * sx_w;

    // Saturate the incoming mean to 13-bit signed so its square fits 25 bits
    always_comb begin
        ex_sat = i_Ex[12:0];
        if ($signed(i_Ex) > 22'sd4095) begin
            ex_sat = 13'sd4095;
        end else if ($signed(i_Ex) < -22'sd4096) begin
            ex_sat = -13'sd4096;
        end
    end

    assign ex_w = 25'(ex_q);
    assign diff = $signed({1'b0, ex2_q}) - $signed({2'b00, exsq_q});
    assign pos  = diff[26] ? 26'd0 : diff[25:0];

    // The mean is only frozen once the calculation has started
    assign ex_capture = i_Ex_done && (state_q != S_CALC) && (state_q != S_SUB)
                        && (state_q != S_HOLD);

`ifdef VAR_EPS_EN
    logic [26:0] eps_sum;
    assign eps_sum = {1'b0, pos} + {19'd0, i_eps};
`endif

    // State register and datapath registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            ex_q      <= '0;
            ex_seen_q <= 1'b0;
            ex2_q     <= '0;
            exsq_q    <= '0;
            var_q     <= '0;
            clamp_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ex_q      <= ex_d;
            ex_seen_q <= ex_seen_d;
            ex2_q     <= ex2_d;
            exsq_q    <= exsq_d;
            var_q     <= var_d;
            clamp_q   <= clamp_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ex_d      = ex_q;
        ex_seen_d = ex_seen_q;
        ex2_d     = ex2_q;
        exsq_d    = exsq_q;
        var_d     = var_q;
        clamp_d   = clamp_q;
        valid_d   = valid_q;

        if (ex_capture) begin
            ex_d      = ex_sat;
            ex_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    acc_d   = {3'b000, sq};
                    cnt_d   = CW'(1);
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (i_valid) begin
                    acc_d = acc_q + {3'b000, sq};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SAMPLES - 1)) begin
                        state_d = S_WAIT_EX;
                    end
                end
            end
            S_WAIT_EX: begin
                // A pulse arriving this cycle is latched on the same edge,
                // so CALC can already use it.
                if (ex_seen_q || i_Ex_done) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                ex2_d   = 26'(({8'd0, acc_q} * {26'd0, i_inv_n}) >> 8);
                exsq_d  = ex_w * ex_w;
                state_d = S_SUB;
            end
            S_SUB: begin
                clamp_d   = diff[26];
`ifdef VAR_EPS_EN
                var_d     = eps_sum[26] ? '1 : eps_sum[25:0];
`else
                var_d     = pos;
`endif
                valid_d   = 1'b1;
                ex_seen_d = 1'b0;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (i_var_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_var_valid = valid_q;
    assign o_var       = var_q;
    assign o_clamp     = clamp_q;
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_ACC);

endmodule

// File: tb/tb_var_unit.sv
// Self-checking bench for var_unit: table of vectors with hand-derived
// expected results pushed to a scoreboard, plus reset/backpressure sequences.
module tb_var_unit;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_valid;
    logic [8:0]  i_x;
    logic [1:0]  i_alpha;
    logic [7:0]  i_inv_n;
    logic        i_Ex_done;
    logic [21:0] i_Ex;
    logic        i_var_ready;
    logic        o_var_valid;
    logic [25:0] o_var;
    logic        o_clamp;
    logic        o_busy;

`ifdef VAR_EPS_EN
    logic [7:0]  i_eps = 8'd3;
    localparam int EPS = 3;
`else
    localparam int EPS = 0;
`endif

    always #5 i_clk = ~i_clk;

    var_unit #(.SAMPLES(8), .XW(9)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_valid     (i_valid),
        .i_x         (i_x),
        .i_alpha     (i_alpha),
        .i_inv_n     (i_inv_n),
        .i_Ex_done   (i_Ex_done),
        .i_Ex        (i_Ex),
        .i_var_ready (i_var_ready),
`ifdef VAR_EPS_EN
        .i_eps       (i_eps),
`endif
        .o_var_valid (o_var_valid),
        .o_var       (o_var),
        .o_clamp     (o_clamp),
        .o_busy      (o_busy)
    );

    typedef struct {
        int xa;
        int xb;
        bit ramp;
        int alpha;
        int inv_n;
        bit early_en;
        int early;
        bit late_en;
        int late;
        int exp_var;
        bit exp_clamp;
        int stall;
    } vec_t;

    typedef struct {
        int v;
        bit c;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int with_eps(input int base);
        int r;
        r = base + EPS;
        if (r > 67108863) r = 67108863;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        logic [25:0] saved;
        e.v = with_eps(v.exp_var);
        e.c = v.exp_clamp;
        sb_q.push_back(e);

        if (v.early_en) begin
            i_Ex_done = 1'b1;
            i_Ex      = 22'(v.early);
            tick();
            i_Ex_done = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_x     = 9'(v.ramp ? (i + 1) : ((i % 2 == 0) ? v.xa : v.xb));
            i_alpha = 2'(v.alpha);
            i_inv_n = 8'(v.inv_n);
            tick();
        end
        i_valid = 1'b0;
        lat = 1;
        if (v.late_en) begin
            i_Ex_done = 1'b1;
            i_Ex      = 22'(v.late);
        end
        while (!o_var_valid && lat < 50) begin
            tick();
            i_Ex_done = 1'b0;
            lat++;
        end
        i_Ex_done = 1'b0;

        if (!o_var_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: o_var_valid still 0 after %0d cycles, expected 1", tag, lat);
        end else begin
            check({tag, " latency"}, lat, 4);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s scoreboard: got result with empty queue, expected entry", tag);
            end else begin
                got = sb_q.pop_front();
                check({tag, " var"}, o_var, got.v);
                check({tag, " clamp"}, o_clamp, got.c);
            end
        end

        saved = o_var;
        for (int s = 0; s < v.stall; s++) begin
            i_valid = 1'b1;
            i_x     = 9'd100;
            tick();
            check({tag, " hold valid"}, o_var_valid, 1);
            check({tag, " hold var"}, o_var, saved);
            check({tag, " hold busy"}, o_busy, 1);
        end
        i_var_ready = 1'b1;
        i_valid     = (v.stall > 0);
        tick();
        i_var_ready = 1'b0;
        i_valid     = 1'b0;
        check({tag, " release valid"}, o_var_valid, 0);
        check({tag, " release busy"}, o_busy, 0);
    endtask

    initial begin
        vec_t rv;
        //         xa    xb  ramp al inv  ee  early  le  late   var    cl stall
        vecs[0] = '{3,    -3,    0, 1, 32, 0, 0,     1, 0,     36,    0, 5};
        vecs[1] = '{4,     4,    0, 0, 32, 0, 0,     1, 4,     0,     0, 0};
        vecs[2] = '{1,     1,    0, 0, 32, 0, 0,     1, 10,    0,     1, 0};
        vecs[3] = '{-256, -256,  0, 3, 32, 0, 0,     1, -2048, 0,     0, 0};
        vecs[4] = '{-256, -256,  0, 3, 32, 0, 0,     1, -5000, 0,     1, 0};
        vecs[5] = '{0,     0,    1, 0, 32, 1, 4,     0, 0,     9,     0, 0};
        vecs[6] = '{4,     4,    0, 0, 32, 1, 100,   1, 4,     0,     0, 0};
        vecs[7] = '{7,     1,    0, 2, 64, 0, 0,     1, 3,     791,   0, 0};

        i_rstn      = 1'b0;
        i_valid     = 1'b0;
        i_x         = '0;
        i_alpha     = '0;
        i_inv_n     = 8'd32;
        i_Ex_done   = 1'b0;
        i_Ex        = '0;
        i_var_ready = 1'b0;
        #12;
        check("reset valid", o_var_valid, 0);
        check("reset var", o_var, 0);
        check("reset clamp", o_clamp, 0);
        check("reset busy", o_busy, 0);
        i_rstn = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Abort a vector part-way with reset; the following vector must not
        // see any of the aborted beats.
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_x     = 9'd50;
            i_alpha = 2'd0;
            i_inv_n = 8'd32;
            tick();
        end
        i_valid = 1'b0;
        i_rstn  = 1'b0;
        #2;
        check("midrst valid", o_var_valid, 0);
        check("midrst var", o_var, 0);
        check("midrst busy", o_busy, 0);
        #2;
        i_rstn = 1'b1;
        tick();
        rv = '{2, 2, 0, 0, 32, 0, 0, 1, 2, 0, 0, 0};
        run_vec(rv, "after_rst");

        check("scoreboard empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
